output_arbiter: RTL and testbench
=================================

OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter: PTR_W, 9, send-queue pointer width; queue depth SHALL be 2**PTR_W (512).
REQ-002 Port: CLK  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port: RST  in  1  reset; synchronous and active-high.
REQ-004 Port: cpu_valid  in  1  CPU output instruction has a byte.
REQ-005 Port: cpu_data  in  8  CPU byte.
REQ-006 Port: cpu_ready  out  1  CPU byte accepted this cycle when cpu_valid && cpu_ready.
REQ-007 Port: dbg_valid  in  1  debug/exception reporter has a byte.
REQ-008 Port: dbg_data  in  8  debug byte.
REQ-009 Port: dbg_last  in  1  final byte of a debug message.
REQ-010 Port: dbg_ready  out  1  debug byte accepted this cycle when dbg_valid && dbg_ready.
REQ-011 Port: send_queue  out  8 x 512  circular byte storage read by the UART output manager.
REQ-012 Port: queue_t  out  PTR_W  write (tail) pointer; next free slot.
REQ-013 Port: queue_s  in  PTR_W  read (head) pointer owned by the UART output manager.
REQ-014 Port: full  out  1  queue cannot accept a byte.
REQ-015 Port: level  out  PTR_W  bytes pending = (queue_t - queue_s) mod 512.

Function
REQ-016 full SHALL be combinational: (queue_t + 1) mod 512 == queue_s; usable capacity SHALL be 511 bytes.
REQ-017 level SHALL be combinational modulo-512 subtraction; empty when queue_t == queue_s.
REQ-018 At most one byte SHALL be written per cycle.
REQ-019 Accepted byte SHALL be written to send_queue[queue_t] and queue_t incremented on the same edge, wrapping 511 -> 0; write visible to the consumer the cycle after acceptance.
REQ-020 cpu_ready and dbg_ready SHALL be combinational from grant state, valids and full; never both 1 in the same cycle; both 0 while full.
REQ-021 FSM states: RR (round-robin) and DBG_LOCK.
REQ-022 In RR, only one valid: that requester SHALL be granted; both valid: the requester not served on the last accepted byte SHALL be granted.
REQ-023 In RR, an accepted debug byte with dbg_last=0 SHALL move FSM to DBG_LOCK; with dbg_last=1 FSM SHALL stay in RR.
REQ-024 In DBG_LOCK, cpu_ready SHALL be 0 regardless of dbg_valid; dbg_ready = dbg_valid && !full.
REQ-025 In DBG_LOCK, an accepted byte with dbg_last=1 SHALL return FSM to RR with last-served = debug.
REQ-026 full during DBG_LOCK SHALL stall the message without releasing the lock; no byte dropped or duplicated.
REQ-027 No byte SHALL ever be written while full; an unaccepted valid SHALL hold (requester keeps data stable).
REQ-028 queue_s moving in the same cycle as a write SHALL be handled correctly; full/level reflect the pre-edge pointer values.

Reset
REQ-029 RST high at an edge SHALL set queue_t=0, FSM=RR, last-served=debug (CPU wins first tie).
REQ-030 During RST, cpu_ready=0 and dbg_ready=0; no write occurs.
REQ-031 send_queue contents SHALL NOT be reset.
REQ-032 RST mid-message (DBG_LOCK) SHALL drop the lock; the partial message remains in the queue only up to its last accepted byte.

Verification
REQ-033 Reset, queue_s=0, cpu_valid 3 cycles with 0x41,0x42,0x43 -> send_queue[0..2]=41,42,43, queue_t=3, level=3.
REQ-034 cpu_valid and dbg_valid (last=1) held high together 4 cycles after reset -> accept order cpu,dbg,cpu,dbg; queue_t=4.
REQ-035 dbg message 3 bytes (last on 3rd) with cpu_valid high throughout -> cpu_ready=0 during bytes 2-3; cpu byte written at slot 3.
REQ-036 queue_s=0, write 511 bytes -> full=1, level=511, both readys 0; queue_s stepped to 1 -> next byte written to slot 511, queue_t wraps to 0.
REQ-037 RST asserted after byte 1 of a 4-byte dbg message -> queue_t=0, FSM=RR, cpu_valid granted on the next cycle.

Source files
------------

// File: rtl/output_arbiter_if.sv
// output_arbiter_if: requester handshakes and send-queue view shared by the arbiter and its users.
// Rev 1.0
`default_nettype none

interface output_arbiter_if #(
  parameter int PTR_W = 9
);
  localparam int DEPTH = 2 ** PTR_W;

  logic             cpu_valid;
  logic [7:0]       cpu_data;
  logic             cpu_ready;
  logic             dbg_valid;
  logic [7:0]       dbg_data;
  logic             dbg_last;
  logic             dbg_ready;
  logic [7:0]       send_queue [DEPTH];
  logic [PTR_W-1:0] queue_t;
  logic [PTR_W-1:0] queue_s;
  logic             full;
  logic [PTR_W-1:0] level;

  modport master (
    output cpu_valid, cpu_data, dbg_valid, dbg_data, dbg_last, queue_s,
    input  cpu_ready, dbg_ready, send_queue, queue_t, full, level
  );

  modport slave (
    input  cpu_valid, cpu_data, dbg_valid, dbg_data, dbg_last, queue_s,
    output cpu_ready, dbg_ready, send_queue, queue_t, full, level
  );
endinterface

`default_nettype wire

// File: rtl/output_arbiter.sv
// output_arbiter: merges CPU and debug byte streams into a circular send queue.
// Rev 1.0 -- round-robin with debug-message locking.
`default_nettype none

module output_arbiter #(
  parameter int PTR_W = 9
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  output_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_RR       = 1'b0,
    ST_DBG_LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             last_dbg_q, last_dbg_d;
  logic [PTR_W-1:0] queue_t_q, queue_t_d;

  logic             full_c;
  logic             grant_cpu;
  logic             grant_dbg;
  logic             cpu_acc;
  logic             dbg_acc;
  logic [7:0]       wr_data;

  assign full_c      = (queue_t_q + PTR_W'(1)) == bus.queue_s;
  assign bus.full    = full_c;
  assign bus.level   = queue_t_q - bus.queue_s;
  assign bus.queue_t = queue_t_q;

  // In RR a tie goes to whichever side was not served on the last accepted byte.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (state_q == ST_DBG_LOCK) begin
      grant_dbg = bus.dbg_valid;
    end else begin
      grant_cpu = bus.cpu_valid && (!bus.dbg_valid || last_dbg_q);
      grant_dbg = bus.dbg_valid && !grant_cpu;
    end
  end

  assign bus.cpu_ready = grant_cpu && !full_c && !RST;
  assign bus.dbg_ready = grant_dbg && !full_c && !RST;
  assign cpu_acc       = bus.cpu_valid && bus.cpu_ready;
  assign dbg_acc       = bus.dbg_valid && bus.dbg_ready;
  assign wr_data       = dbg_acc ? bus.dbg_data : bus.cpu_data;

  always_comb begin
    state_d    = state_q;
    last_dbg_d = last_dbg_q;
    queue_t_d  = queue_t_q;
    if (cpu_acc || dbg_acc) begin
      queue_t_d  = queue_t_q + PTR_W'(1);
      last_dbg_d = dbg_acc;
    end
    if (dbg_acc) begin
      state_d = bus.dbg_last ? ST_RR : ST_DBG_LOCK;
    end
  end

  // Queue storage is deliberately left out of reset; only the pointer is cleared.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_RR;
      last_dbg_q <= 1'b1;
      queue_t_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_dbg_q <= last_dbg_d;
      queue_t_q  <= queue_t_d;
      if (cpu_acc || dbg_acc) begin
        bus.send_queue[queue_t_q] <= wr_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: directed stimulus with a queue-based scoreboard for output_arbiter.
// Rev 1.0
`default_nettype none

module tb_output_arbiter;
  localparam int PTR_W = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_arbiter_if #(.PTR_W(PTR_W)) bus ();

  output_arbiter #(.PTR_W(PTR_W)) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic             src;   // 1 = debug, 0 = cpu
    logic [7:0]       data;
    logic [PTR_W-1:0] slot;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic s, input logic [7:0] d, input int slot);
    exp_t e;
    e.src  = s;
    e.data = d;
    e.slot = slot[PTR_W-1:0];
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Monitor: every accepted byte is matched against the next expected entry,
  // and the stored byte is read back one cycle later.
  logic             pend = 1'b0;
  logic [PTR_W-1:0] pend_slot;
  logic [7:0]       pend_data;

  initial begin
    logic       src;
    logic [7:0] data;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("mem_content", {24'd0, bus.send_queue[pend_slot]}, {24'd0, pend_data});
        pend = 1'b0;
      end
      chk("ready_exclusive", {31'd0, bus.cpu_ready & bus.dbg_ready}, 32'd0);
      if ((bus.cpu_valid && bus.cpu_ready) || (bus.dbg_valid && bus.dbg_ready)) begin
        src  = bus.dbg_valid && bus.dbg_ready;
        data = src ? bus.dbg_data : bus.cpu_data;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: got src=%0d data=0x%0h slot=%0d expected none", src, data, bus.queue_t);
        end else begin
          e = exp_q.pop_front();
          chk("accept_src",  {31'd0, src}, {31'd0, e.src});
          chk("accept_data", {24'd0, data}, {24'd0, e.data});
          chk("accept_slot", {23'd0, bus.queue_t}, {23'd0, e.slot});
        end
        pend      = 1'b1;
        pend_slot = bus.queue_t;
        pend_data = data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.queue_s   = '0;
    bus.cpu_valid = 1'b1;
    bus.cpu_data  = 8'hAA;
    bus.dbg_valid = 1'b1;
    bus.dbg_data  = 8'hBB;
    bus.dbg_last  = 1'b1;

    // Reset state with both requesters asking.
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
    chk("rst_dbg_ready", {31'd0, bus.dbg_ready}, 32'd0);
    chk("rst_queue_t",   {23'd0, bus.queue_t}, 32'd0);
    chk("rst_level",     {23'd0, bus.level}, 32'd0);
    chk("rst_full",      {31'd0, bus.full}, 32'd0);
    bus.cpu_valid = 1'b0;
    bus.dbg_valid = 1'b0;
    cyc();
    rst = 1'b0;

    // Three CPU bytes.
    push(1'b0, 8'h41, 0);
    push(1'b0, 8'h42, 1);
    push(1'b0, 8'h43, 2);
    bus.cpu_valid = 1'b1;
    bus.cpu_data  = 8'h41; cyc();
    bus.cpu_data  = 8'h42; cyc();
    bus.cpu_data  = 8'h43; cyc();
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    chk("cpu3_queue_t", {23'd0, bus.queue_t}, 32'd3);
    chk("cpu3_level",   {23'd0, bus.level}, 32'd3);
    chk("cpu3_full",    {31'd0, bus.full}, 32'd0);

    // Round-robin tie: cpu, dbg, cpu, dbg.
    do_reset();
    push(1'b0, 8'hA0, 0);
    push(1'b1, 8'hD0, 1);
    push(1'b0, 8'hA1, 2);
    push(1'b1, 8'hD1, 3);
    bus.cpu_valid = 1'b1; bus.cpu_data = 8'hA0;
    bus.dbg_valid = 1'b1; bus.dbg_data = 8'hD0; bus.dbg_last = 1'b1;
    cyc();
    bus.cpu_data = 8'hA1;
    cyc();
    bus.dbg_data = 8'hD1;
    cyc();
    cyc();
    bus.cpu_valid = 1'b0;
    bus.dbg_valid = 1'b0;
    @(negedge clk);
    chk("rr_queue_t", {23'd0, bus.queue_t}, 32'd4);

    // Three-byte debug message locks out the CPU.
    do_reset();
    push(1'b1, 8'h10, 0);
    push(1'b1, 8'h11, 1);
    push(1'b1, 8'h12, 2);
    push(1'b0, 8'h55, 3);
    bus.dbg_valid = 1'b1; bus.dbg_data = 8'h10; bus.dbg_last = 1'b0;
    cyc();
    bus.dbg_data  = 8'h11;
    bus.cpu_valid = 1'b1; bus.cpu_data = 8'h55;
    @(negedge clk);
    chk("lock_b2_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
    chk("lock_b2_dbg_ready", {31'd0, bus.dbg_ready}, 32'd1);
    cyc();
    bus.dbg_data = 8'h12; bus.dbg_last = 1'b1;
    @(negedge clk);
    chk("lock_b3_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
    cyc();
    bus.dbg_valid = 1'b0;
    @(negedge clk);
    chk("unlock_cpu_ready", {31'd0, bus.cpu_ready}, 32'd1);
    cyc();
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    chk("lock_queue_t", {23'd0, bus.queue_t}, 32'd4);

    // Fill to capacity, then free one slot and wrap the tail pointer.
    do_reset();
    bus.cpu_valid = 1'b1;
    for (int i = 0; i < 511; i++) begin
      push(1'b0, i[7:0], i);
      bus.cpu_data = i[7:0];
      cyc();
    end
    bus.cpu_data  = 8'hEE;
    bus.dbg_valid = 1'b1; bus.dbg_data = 8'hBB; bus.dbg_last = 1'b1;
    @(negedge clk);
    chk("full_flag",      {31'd0, bus.full}, 32'd1);
    chk("full_level",     {23'd0, bus.level}, 32'd511);
    chk("full_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
    chk("full_dbg_ready", {31'd0, bus.dbg_ready}, 32'd0);
    chk("full_queue_t",   {23'd0, bus.queue_t}, 32'd511);
    cyc();
    push(1'b0, 8'hEE, 511);
    bus.dbg_valid = 1'b0;
    bus.queue_s   = 9'd1;
    @(negedge clk);
    chk("drain_full",  {31'd0, bus.full}, 32'd0);
    chk("drain_level", {23'd0, bus.level}, 32'd510);
    cyc();
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    chk("wrap_queue_t", {23'd0, bus.queue_t}, 32'd0);
    chk("wrap_full",    {31'd0, bus.full}, 32'd1);
    chk("wrap_level",   {23'd0, bus.level}, 32'd511);

    // Reset in the middle of a locked debug message.
    bus.queue_s = '0;
    do_reset();
    push(1'b1, 8'h20, 0);
    bus.dbg_valid = 1'b1; bus.dbg_data = 8'h20; bus.dbg_last = 1'b0;
    cyc();
    rst = 1'b1;
    bus.dbg_data  = 8'h21; bus.dbg_last = 1'b1;
    bus.cpu_valid = 1'b1;  bus.cpu_data = 8'h77;
    @(negedge clk);
    chk("midrst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
    chk("midrst_dbg_ready", {31'd0, bus.dbg_ready}, 32'd0);
    push(1'b0, 8'h77, 0);
    push(1'b1, 8'h21, 1);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_queue_t",   {23'd0, bus.queue_t}, 32'd0);
    chk("postrst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd1);
    cyc();
    bus.cpu_valid = 1'b0;
    cyc();
    bus.dbg_valid = 1'b0;
    @(negedge clk);
    chk("postrst_final_queue_t", {23'd0, bus.queue_t}, 32'd2);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
